// File: rtl/cynapse_pkg.sv
// Shared definitions for the spiking-core datapath: default neuron index width
// and the end-of-timestep marker FSM encoding.
package cynapse_pkg;

  localparam int NEURON_ID_WIDTH_DEF = 11;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } marker_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is read combinationally
// from storage so a write becomes visible one cycle later.
module sync_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries data only; pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_out_queue.sv
// Output queue between the threshold unit and the synapse stage: buffers spiking
// neuron indices and inserts one end-of-timestep marker per TimestepDone.
module spike_out_queue
  import cynapse_pkg::*;
#(
  parameter int NEURON_ID_WIDTH = NEURON_ID_WIDTH_DEF,
  parameter int DEPTH           = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       SpikeValid,
  input  logic                       SpikeIn,
  input  logic [NEURON_ID_WIDTH-1:0] NeuronID,
  input  logic                       TimestepDone,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [NEURON_ID_WIDTH-1:0] OutNeuronID,
  output logic                       OutEndOfStep,
  output logic                       Full,
  output logic                       Empty,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow,
  input  logic                       ClearOverflow
);

  localparam int DATA_W = NEURON_ID_WIDTH + 1;

  marker_state_e     state;
  logic              spike_req;
  logic              marker_wr;
  logic              spike_wr;
  logic              drop;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  // A pending marker owns the write port; any spike in that cycle is lost.
  always_comb begin
    spike_req = SpikeValid & SpikeIn;
    marker_wr = (state == PEND) & ~Full;
    spike_wr  = (state == IDLE) & spike_req & ~Full;
    drop      = spike_req & ~spike_wr;
    wr_en     = marker_wr | spike_wr;
    wr_data   = marker_wr ? {1'b1, {NEURON_ID_WIDTH{1'b0}}} : {1'b0, NeuronID};
    rd_en     = OutReady & ~Empty;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (Clock),
    .rst     (Reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (Full),
    .empty   (Empty),
    .count   (Count)
  );

  assign OutValid                    = ~Empty;
  assign {OutEndOfStep, OutNeuronID} = rd_data;

  // TimestepDone while PEND is ignored, so at most one marker is outstanding.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (TimestepDone) state <= PEND;
        PEND:    if (!Full) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (drop) begin
        Overflow <= 1'b1;
      end else if (ClearOverflow) begin
        Overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_out_queue.sv
// Directed bench for spike_out_queue: ordering, overflow drops, marker insertion,
// pointer wrap under backpressure and mid-run reset.
module tb_spike_out_queue;

  localparam int W  = 11;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          SpikeValid;
  logic          SpikeIn;
  logic [W-1:0]  NeuronID;
  logic          TimestepDone;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  OutNeuronID;
  logic          OutEndOfStep;
  logic          Full;
  logic          Empty;
  logic [CW-1:0] Count;
  logic          Overflow;
  logic          ClearOverflow;

  int vectors     = 0;
  int miscompares = 0;
  int sent;
  int recv;
  int t1_ids [3] = '{3, 7, 9};

  spike_out_queue #(
    .NEURON_ID_WIDTH (W),
    .DEPTH           (D)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .SpikeValid    (SpikeValid),
    .SpikeIn       (SpikeIn),
    .NeuronID      (NeuronID),
    .TimestepDone  (TimestepDone),
    .OutValid      (OutValid),
    .OutReady      (OutReady),
    .OutNeuronID   (OutNeuronID),
    .OutEndOfStep  (OutEndOfStep),
    .Full          (Full),
    .Empty         (Empty),
    .Count         (Count),
    .Overflow      (Overflow),
    .ClearOverflow (ClearOverflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input int id, input logic td);
    SpikeValid   = v;
    SpikeIn      = s;
    NeuronID     = W'(id);
    TimestepDone = td;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1;
    OutReady = 1'b0;
    ClearOverflow = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0);
    cyc();
    cyc();
    Reset = 1'b0;
    chk("rst_count", 32'(Count), 0);
    chk("rst_empty", 32'(Empty), 1);
    chk("rst_full", 32'(Full), 0);
    chk("rst_valid", 32'(OutValid), 0);
    chk("rst_ovf", 32'(Overflow), 0);

    // Three spikes with a non-spike in between, then drain in order.
    drive(1'b1, 1'b1, 3, 1'b0);
    cyc();
    chk("t1_latency_valid", 32'(OutValid), 1);
    chk("t1_count1", 32'(Count), 1);
    drive(1'b1, 1'b1, 7, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 5, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 9, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t1_count3", 32'(Count), 3);
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_valid", 32'(OutValid), 1);
      chk("t1_id", 32'(OutNeuronID), t1_ids[i]);
      chk("t1_eos", 32'(OutEndOfStep), 0);
      cyc();
    end
    chk("t1_empty", 32'(Empty), 1);
    OutReady = 1'b0;

    // Fill, overflow with clear in the same cycle, drain.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 100 + i, 1'b0);
      cyc();
    end
    chk("t2_count16", 32'(Count), 16);
    chk("t2_full", 32'(Full), 1);
    chk("t2_ovf_before", 32'(Overflow), 0);
    drive(1'b1, 1'b1, 20, 1'b0);
    ClearOverflow = 1'b1;
    cyc();
    drive(1'b0, 1'b0, 0, 1'b0);
    ClearOverflow = 1'b0;
    chk("t2_ovf_set_wins", 32'(Overflow), 1);
    chk("t2_count_hold", 32'(Count), 16);
    chk("t2_full_hold", 32'(Full), 1);
    OutReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain_id", 32'(OutNeuronID), 100 + i);
      cyc();
    end
    chk("t2_empty", 32'(Empty), 1);
    OutReady = 1'b0;
    ClearOverflow = 1'b1;
    cyc();
    ClearOverflow = 1'b0;
    chk("t2_ovf_cleared", 32'(Overflow), 0);

    // Spike and TimestepDone together: spike first, marker after.
    OutReady = 1'b1;
    drive(1'b1, 1'b1, 42, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t3_valid", 32'(OutValid), 1);
    chk("t3_id42", 32'(OutNeuronID), 42);
    chk("t3_eos0", 32'(OutEndOfStep), 0);
    cyc();
    chk("t3_mk_valid", 32'(OutValid), 1);
    chk("t3_mk_eos", 32'(OutEndOfStep), 1);
    chk("t3_mk_id0", 32'(OutNeuronID), 0);
    cyc();
    chk("t3_empty", 32'(Empty), 1);
    OutReady = 1'b0;

    // 40-spike stream with OutReady toggling; producer respects Full.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 400 && recv < 40; c++) begin
      OutReady = ((c % 2) == 1);
      if (sent < 40 && !Full) begin
        drive(1'b1, 1'b1, 300 + sent, 1'b0);
        sent++;
      end else begin
        drive(1'b0, 1'b0, 0, 1'b0);
      end
      if (OutValid && OutReady) begin
        chk("t5_order", 32'(OutNeuronID), 300 + recv);
        recv++;
      end
      cyc();
      chk("t5_bound", 32'(Count <= 5'd16), 1);
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    OutReady = 1'b0;
    chk("t5_recv40", recv, 40);
    chk("t5_ovf", 32'(Overflow), 0);
    chk("t5_empty", 32'(Empty), 1);

    // Marker pending on a full queue; one read frees space, marker beats a spike.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 200 + i, 1'b0);
      cyc();
    end
    drive(1'b0, 1'b0, 0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t4_count_full", 32'(Count), 16);
    chk("t4_head200", 32'(OutNeuronID), 200);
    OutReady = 1'b1;
    cyc();
    OutReady = 1'b0;
    chk("t4_count15", 32'(Count), 15);
    chk("t4_ovf_before", 32'(Overflow), 0);
    drive(1'b1, 1'b1, 77, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t4_count16", 32'(Count), 16);
    chk("t4_ovf_drop", 32'(Overflow), 1);
    OutReady = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("t4_drain_id", 32'(OutNeuronID), 201 + i);
      chk("t4_drain_eos", 32'(OutEndOfStep), 0);
      cyc();
    end
    chk("t4_mk_eos", 32'(OutEndOfStep), 1);
    chk("t4_mk_id0", 32'(OutNeuronID), 0);
    cyc();
    chk("t4_empty", 32'(Empty), 1);
    cyc();
    cyc();
    chk("t4_single_marker", 32'(Empty), 1);
    OutReady = 1'b0;

    // Reset with five entries, a pending marker and Overflow set.
    chk("t6_ovf_pre", 32'(Overflow), 1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 400 + i, (i == 4));
      cyc();
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t6_count5", 32'(Count), 5);
    Reset = 1'b1;
    drive(1'b1, 1'b1, 500, 1'b1);
    cyc();
    Reset = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t6_empty", 32'(Empty), 1);
    chk("t6_valid", 32'(OutValid), 0);
    chk("t6_ovf", 32'(Overflow), 0);
    chk("t6_count0", 32'(Count), 0);
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_no_marker", 32'(Empty), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spike_out_queue.md
SPIKE_OUT_QUEUE -- requirements
Module: spike_out_queue

Interface
REQ-001 Parameter NEURON_ID_WIDTH, default 11: width of the neuron index carried with each spike.
REQ-002 Parameter DEPTH, default 16: number of queue entries; power of two, at least 4.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 SpikeValid  input  1  threshold-unit result for NeuronID is presented this cycle.
REQ-006 SpikeIn  input  1  threshold-unit spike decision; it is meaningful only when SpikeValid=1.
REQ-007 NeuronID  input  NEURON_ID_WIDTH  index of the neuron evaluated this cycle.
REQ-008 TimestepDone  input  1  single-cycle pulse marking that the last neuron of the timestep has been presented.
REQ-009 OutValid  output  1  head entry available.
REQ-010 OutReady  input  1  downstream synapse stage accepts the head entry.
REQ-011 OutNeuronID  output  NEURON_ID_WIDTH  neuron index of the head entry.
REQ-012 OutEndOfStep  output  1  head entry is an end-of-timestep marker; OutNeuronID=0 for markers.
REQ-013 Full  output  1  Count==DEPTH.
REQ-014 Empty  output  1  Count==0.
REQ-015 Count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-016 Overflow  output  1  sticky flag: at least one spike has been dropped.
REQ-017 ClearOverflow  input  1  clears Overflow.

Function
REQ-018 A spike write request exists when SpikeValid=1 and SpikeIn=1; SpikeValid=1 with SpikeIn=0 SHALL store nothing.
REQ-019 Each entry SHALL hold {EndOfStep, NeuronID}, and entries SHALL leave the queue in strict arrival order.
REQ-020 A read SHALL occur when OutValid=1 and OutReady=1; the outputs SHALL present the head entry combinationally from storage, with OutValid=~Empty.
REQ-021 Latency from a write to OutValid on an empty queue SHALL be 1 cycle; there is no same-cycle bypass.
REQ-022 A write SHALL be accepted only if Full=0 at the start of the cycle; a read in the same cycle does not free space for that cycle's write.
REQ-023 Count SHALL increment on a write alone, decrement on a read alone, and stay unchanged on a simultaneous write and read.
REQ-024 A rejected spike (the queue is full, or blocked per REQ-027) SHALL be dropped and SHALL set Overflow on the next edge.
REQ-025 Marker FSM states:
  - IDLE: on TimestepDone, go to PEND.
  - PEND: write the marker when Full=0 and return to IDLE; otherwise stay in PEND.
REQ-026 A marker SHALL never be dropped; it waits in PEND until space exists.
REQ-027 In PEND, the marker write SHALL have priority over any spike write; a spike presented that cycle SHALL be dropped.
REQ-028 TimestepDone coincident with a spike write in IDLE:
  - the spike SHALL be written that cycle;
  - the marker SHALL be written at the earliest following cycle with space.
REQ-029 TimestepDone received while in PEND SHALL be ignored; at most one marker is outstanding.
REQ-030 ClearOverflow and a new drop in the same cycle SHALL leave Overflow=1 (the set wins).
REQ-031 Read and write pointers SHALL wrap modulo DEPTH with no loss at the wrap boundary.

Reset
REQ-032 Reset SHALL force Count=0, Empty=1, Full=0, OutValid=0, Overflow=0, the FSM to IDLE, and both pointers to 0.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries and any pending marker; the storage array needs no reset.
REQ-034 All inputs SHALL be ignored during any cycle in which Reset=1.

Structure
REQ-035 The shared package cynapse_pkg SHALL hold the NEURON_ID_WIDTH default and the marker FSM state encoding (IDLE, PEND).
REQ-036 Storage and pointers SHALL be a sub-module sync_fifo (synchronous, parameterised width and depth, with full, empty and count outputs).
REQ-037 The marker FSM, the drop logic and Overflow SHALL live in spike_out_queue.

Verification
REQ-038 DEPTH=16, OutReady=0; send spikes on IDs 3, 7 and 9 (SpikeIn=0 on ID 5) -> Count=3; then OutReady=1 -> outputs IDs 3, 7, 9 in order with OutEndOfStep=0.
REQ-039 Fill with 16 spikes, then send a 17th spike (ID 20) -> Full=1, Count=16, Overflow=1 the next cycle, and ID 20 never appears at the output.
REQ-040 Spike ID 42 with TimestepDone in the same cycle, OutReady=1 -> outputs ID 42, then a marker (OutEndOfStep=1, OutNeuronID=0); the marker appears no earlier than 1 cycle after ID 42.
REQ-041 Queue full, TimestepDone pulses -> the FSM holds PEND; a single read frees space -> the marker is written next cycle; a spike offered in that write cycle is dropped and Overflow=1.
REQ-042 Stream 40 spikes with OutReady toggling every cycle -> all 40 IDs are output in order across pointer wraps, Count never exceeds 16, and Overflow=0.
REQ-043 Reset asserted with Count=5 and a marker pending -> the next cycle shows Empty=1, OutValid=0 and Overflow=0, and no marker is emitted afterwards.
